// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-stage definitions: default geometry, FSM encodings and the credit rule.
// Combinational helpers only; no state.
// No flow control of its own.
package instruction_fetch_pkg;

    localparam int               ADDR_WIDTH_DEF  = 16;
    localparam int               DATA_WIDTH_DEF  = 16;
    localparam int               QUEUE_DEPTH_DEF = 2;
    localparam logic [15:0]      RESET_PC_DEF    = 16'h0000;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FETCH  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    // A read may be issued only if its return is guaranteed a queue slot.
    function automatic logic has_credit(input int count, input int inflight,
                                        input int pop, input int depth);
        return (count + inflight - pop) < depth;
    endfunction

endpackage

// File: rtl/instruction_fetch_queue.sv
// Small synchronous FIFO of {pc, instruction} entries with flush and occupancy count.
// Latency: push visible at head the cycle after the push edge (no bypass).
// Backpressure: caller must not push when full; flush beats push and pop.
module fetch_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head_data,
    output logic                         head_valid,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign head_valid = (count != '0);
    assign head_data  = head_valid ? mem[rd_ptr] : '0;
    assign do_pop     = pop & head_valid;
    assign do_push    = push & ((count != CW'(DEPTH)) | do_pop);

    always_ff @(posedge clock) begin
        if (!reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: holds the PC, issues ROM reads, queues returned words for decode.
// Latency: issue at N -> instruction_valid at N+2; one instruction per cycle sustained.
// Backpressure: issue stalls when queue + in-flight would exceed QUEUE_DEPTH; head holds while !ready.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int                    DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = RESET_PC_DEF,
    parameter int                    QUEUE_DEPTH = QUEUE_DEPTH_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  rom_select,
    output logic                  rom_read_enable,
    output logic [ADDR_WIDTH-1:0] rom_address,
    input  logic [DATA_WIDTH-1:0] rom_read_data,
    input  logic                  jump,
    input  logic [ADDR_WIDTH-1:0] jump_target,
    input  logic                  halt,
    output logic [DATA_WIDTH-1:0] instruction,
    output logic [ADDR_WIDTH-1:0] instruction_pc,
    output logic                  instruction_valid,
    input  logic                  instruction_ready
);
    localparam int CW = $clog2(QUEUE_DEPTH + 1);

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] issued_pc;
    logic                  inflight;
    logic [CW-1:0]         count;
    logic                  pop;
    logic                  issue;

    // A jump flushes the queue, so a head presented in the same cycle is not consumed.
    assign pop   = instruction_valid & instruction_ready & ~jump;
    assign issue = reset & ~jump & ~halt & (state == ST_FETCH)
                 & has_credit(int'(count), int'(inflight), int'(pop), QUEUE_DEPTH);

    assign rom_select      = issue;
    assign rom_read_enable = issue;
    assign rom_address     = pc;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= ST_IDLE;
            pc        <= RESET_PC;
            issued_pc <= '0;
            inflight  <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                issued_pc <= pc;
            end
            if (jump) begin
                pc <= jump_target;
            end else if (issue) begin
                pc <= pc + ADDR_WIDTH'(1);
            end
            case (state)
                ST_IDLE:   state <= ST_FETCH;
                ST_FETCH:  if (halt) state <= ST_HALTED;
                ST_HALTED: if (!halt && !jump) state <= ST_FETCH;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    // The returning word lands at the same edge as a jump's flush, which discards it.
    fetch_queue #(
        .WIDTH (ADDR_WIDTH + DATA_WIDTH),
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clock      (clock),
        .reset      (reset),
        .flush      (jump),
        .push       (inflight),
        .push_data  ({issued_pc, rom_read_data}),
        .pop        (pop),
        .head_data  ({instruction_pc, instruction}),
        .head_valid (instruction_valid),
        .count      (count)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: behavioural 1-cycle ROM (ROM[i] = A000+i) and an
// in-order scoreboard of expected PCs checked on every decode handshake.
module tb_instruction_fetch;

    logic        clock = 1'b0;
    logic        reset;
    logic        rom_select;
    logic        rom_read_enable;
    logic [15:0] rom_address;
    logic [15:0] rom_read_data = 16'h0000;
    logic        jump;
    logic [15:0] jump_target;
    logic        halt;
    logic [15:0] instruction;
    logic [15:0] instruction_pc;
    logic        instruction_valid;
    logic        instruction_ready;

    int          total = 0;
    int          bad   = 0;
    int          n_hs  = 0;
    int          n_iss = 0;
    logic [15:0] last_pc = 16'h0000;
    logic [15:0] exp_q[$];

    instruction_fetch dut (
        .clock             (clock),
        .reset             (reset),
        .rom_select        (rom_select),
        .rom_read_enable   (rom_read_enable),
        .rom_address       (rom_address),
        .rom_read_data     (rom_read_data),
        .jump              (jump),
        .jump_target       (jump_target),
        .halt              (halt),
        .instruction       (instruction),
        .instruction_pc    (instruction_pc),
        .instruction_valid (instruction_valid),
        .instruction_ready (instruction_ready)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (rom_read_enable) rom_read_data <= 16'hA000 + rom_address;
    end

    // Scoreboard: every accepted head must be the next expected PC with its ROM word.
    always @(negedge clock) begin
        logic [15:0] ep;
        logic [15:0] ei;
        if (rom_read_enable) n_iss++;
        if (reset && !jump && instruction_valid && instruction_ready) begin
            n_hs++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL stream_extra: got pc=%h instr=%h, required no output", instruction_pc, instruction);
            end else begin
                ep = exp_q.pop_front();
                ei = 16'hA000 + ep;
                last_pc = instruction_pc;
                if (instruction_pc !== ep || instruction !== ei) begin
                    bad++;
                    $display("FAIL stream_order: got pc=%h instr=%h, required pc=%h instr=%h",
                             instruction_pc, instruction, ep, ei);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic load_exp(input logic [15:0] start);
        exp_q.delete();
        for (int i = 0; i < 200; i++) exp_q.push_back(start + 16'(i));
    endtask

    task automatic test_reset;
        reset = 1'b0; jump = 1'b0; jump_target = 16'h0000; halt = 1'b0; instruction_ready = 1'b0;
        cyc(3);
        @(negedge clock);
        total++; if (rom_read_enable !== 1'b0) begin bad++; $display("FAIL reset_ren: got %b required 0", rom_read_enable); end
        total++; if (rom_select !== 1'b0) begin bad++; $display("FAIL reset_sel: got %b required 0", rom_select); end
        total++; if (instruction_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b required 0", instruction_valid); end
        total++; if (instruction !== 16'h0000) begin bad++; $display("FAIL reset_instr: got %h required 0000", instruction); end
        total++; if (instruction_pc !== 16'h0000) begin bad++; $display("FAIL reset_pc: got %h required 0000", instruction_pc); end
        cyc(1);
        load_exp(16'h0000);
        n_iss = 0;
        reset = 1'b1;                                   // cycle 0: IDLE
        @(negedge clock);
        total++; if (rom_read_enable !== 1'b0) begin bad++; $display("FAIL idle_ren: got %b required 0", rom_read_enable); end
        cyc(1);                                         // cycle 1
        @(negedge clock);
        total++; if (rom_read_enable !== 1'b1 || rom_address !== 16'h0000) begin
            bad++; $display("FAIL first_issue: got ren=%b addr=%h required ren=1 addr=0000", rom_read_enable, rom_address); end
        cyc(1);                                         // cycle 2
        @(negedge clock);
        total++; if (rom_address !== 16'h0001 || instruction_valid !== 1'b0) begin
            bad++; $display("FAIL second_issue: got addr=%h valid=%b required addr=0001 valid=0", rom_address, instruction_valid); end
        cyc(1);                                         // cycle 3
    endtask

    task automatic test_backpressure;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            total++;
            if (instruction_valid !== 1'b1 || instruction_pc !== 16'h0000 || instruction !== 16'hA000) begin
                bad++;
                $display("FAIL bp_hold: cycle %0d got valid=%b pc=%h instr=%h required valid=1 pc=0000 instr=A000",
                         k, instruction_valid, instruction_pc, instruction);
            end
            cyc(1);
        end
        total++; if (n_iss !== 2) begin bad++; $display("FAIL bp_credits: got %0d reads issued, required 2", n_iss); end
        instruction_ready = 1'b1;
    endtask

    task automatic test_stream;
        int n0;
        n0 = n_hs;
        cyc(10);
        total++; if (n_hs - n0 !== 10) begin bad++; $display("FAIL stream_rate: got %0d accepts in 10 cycles, required 10", n_hs - n0); end
    endtask

    task automatic test_jump;
        instruction_ready = 1'b0;
        jump = 1'b1; jump_target = 16'h0040;
        load_exp(16'h0040);
        @(negedge clock);
        total++; if (rom_read_enable !== 1'b0) begin bad++; $display("FAIL jump_no_issue: got ren=%b required 0", rom_read_enable); end
        cyc(1);
        jump = 1'b0; instruction_ready = 1'b1;
        @(negedge clock);
        total++; if (instruction_valid !== 1'b0 || rom_read_enable !== 1'b1 || rom_address !== 16'h0040) begin
            bad++; $display("FAIL jump_j1: got valid=%b ren=%b addr=%h required valid=0 ren=1 addr=0040",
                            instruction_valid, rom_read_enable, rom_address); end
        cyc(1);
        @(negedge clock);
        total++; if (instruction_valid !== 1'b0) begin bad++; $display("FAIL jump_j2: got valid=%b required 0", instruction_valid); end
        cyc(1);
        @(negedge clock);
        total++; if (instruction_valid !== 1'b1 || instruction_pc !== 16'h0040 || instruction !== 16'hA040) begin
            bad++; $display("FAIL jump_j3: got valid=%b pc=%h instr=%h required valid=1 pc=0040 instr=A040",
                            instruction_valid, instruction_pc, instruction); end
        cyc(6);
    endtask

    task automatic test_jump_pop;
        jump = 1'b1; jump_target = 16'h0080;
        load_exp(16'h0080);
        @(negedge clock);
        total++; if (instruction_valid !== 1'b1) begin bad++; $display("FAIL jpop_head: got valid=%b required 1", instruction_valid); end
        cyc(1);
        jump = 1'b0;
        @(negedge clock);
        total++; if (instruction_valid !== 1'b0) begin bad++; $display("FAIL jpop_flush: got valid=%b required 0", instruction_valid); end
        cyc(2);
        @(negedge clock);
        total++; if (instruction_valid !== 1'b1 || instruction_pc !== 16'h0080) begin
            bad++; $display("FAIL jpop_restart: got valid=%b pc=%h required valid=1 pc=0080", instruction_valid, instruction_pc); end
        cyc(4);
    endtask

    task automatic test_halt;
        logic [15:0] want;
        halt = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            total++; if (rom_read_enable !== 1'b0) begin bad++; $display("FAIL halt_ren: cycle %0d got %b required 0", k, rom_read_enable); end
            if (k == 3) begin
                total++; if (instruction_valid !== 1'b0) begin bad++; $display("FAIL halt_drain: got valid=%b required 0", instruction_valid); end
            end
            cyc(1);
        end
        halt = 1'b0;
        cyc(1);
        @(negedge clock);
        want = last_pc + 16'h0001;
        total++; if (rom_read_enable !== 1'b1 || rom_address !== want) begin
            bad++; $display("FAIL halt_resume: got ren=%b addr=%h required ren=1 addr=%h", rom_read_enable, rom_address, want); end
        cyc(6);
    endtask

    task automatic test_wrap;
        jump = 1'b1; jump_target = 16'hFFFE;
        load_exp(16'hFFFE);
        cyc(1);
        jump = 1'b0;
        @(negedge clock);
        total++; if (rom_address !== 16'hFFFE) begin bad++; $display("FAIL wrap_a: got addr=%h required FFFE", rom_address); end
        cyc(1);
        @(negedge clock);
        total++; if (rom_address !== 16'hFFFF) begin bad++; $display("FAIL wrap_b: got addr=%h required FFFF", rom_address); end
        cyc(1);
        @(negedge clock);
        total++; if (rom_read_enable !== 1'b1 || rom_address !== 16'h0000) begin
            bad++; $display("FAIL wrap_c: got ren=%b addr=%h required ren=1 addr=0000", rom_read_enable, rom_address); end
        cyc(6);
    endtask

    task automatic test_reset_mid;
        logic got;
        reset = 1'b0;
        cyc(1);
        @(negedge clock);
        total++; if (instruction_valid !== 1'b0 || instruction !== 16'h0000 || instruction_pc !== 16'h0000 ||
                     rom_read_enable !== 1'b0 || rom_select !== 1'b0) begin
            bad++; $display("FAIL midreset_out: got valid=%b instr=%h pc=%h ren=%b sel=%b required all 0",
                            instruction_valid, instruction, instruction_pc, rom_read_enable, rom_select); end
        cyc(1);
        load_exp(16'h0000);
        reset = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clock);
            got = instruction_valid;
            if (!got) cyc(1);
        end
        total++;
        if (!got) begin
            bad++; $display("FAIL midreset_timeout: got no valid within 10 cycles, required valid");
        end else if (instruction_pc !== 16'h0000) begin
            bad++; $display("FAIL midreset_first: got pc=%h required 0000", instruction_pc);
        end
        cyc(6);
    endtask

    initial begin
        test_reset();
        test_backpressure();
        test_stream();
        test_jump();
        test_jump_pop();
        test_halt();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
